sokoban_state_store: RTL and testbench

Game-state register and undo history for the Sokoban core. It sits downstream of the game controller. It acts on the controller's `game_state_en` / `sel` / `step_inc` / `step_dec` strobes to:
- load a level's initial state,
- commit a move, or
- pop a previous state.

It returns to the controller the current packed `game_state`, the step count, and `real_retract`, which reports whether an undo is available.

---
 rtl/sokoban_state_store_if.sv | 23 ++
 rtl/sokoban_state_store.sv | 86 ++++++++
 tb/tb_sokoban_state_store.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sokoban_state_store_if.sv
// Controller <-> state-store bundle: update strobes and source states in,
// current packed state, step count and undo availability out.
interface sokoban_state_store_if;
  logic         game_state_en;
  logic [1:0]   sel;
  logic         step_inc;
  logic         step_dec;
  logic [133:0] init_state;
  logic [133:0] move_state;
  logic [133:0] game_state;
  logic [7:0]   step;
  logic         real_retract;

  modport master (
    output game_state_en, sel, step_inc, step_dec, init_state, move_state,
    input  game_state, step, real_retract
  );

  modport slave (
    input  game_state_en, sel, step_inc, step_dec, init_state, move_state,
    output game_state, step, real_retract
  );
endinterface

// File: rtl/sokoban_state_store.sv
// Sokoban game-state register with a circular undo history and a saturating
// step counter. Oldest history entries are overwritten once the ring is full.
module sokoban_state_store #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic                  clk,
  input logic                  reset,
  sokoban_state_store_if.slave sif
);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [133:0]  state_q, state_d;
  logic [133:0]  hist_q [DEPTH];
  logic [133:0]  hist_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    step_q, step_d;
  logic          load;

  assign load = sif.game_state_en && (sif.sel == 2'b00);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    if (sif.game_state_en) begin
      case (sif.sel)
        2'b00: begin
          state_d = sif.init_state;
          wp_d    = '0;
          cnt_d   = '0;
        end
        2'b01: begin
          hist_d[wp_q] = state_q;
          wp_d         = wp_q + AW'(1);
          state_d      = sif.move_state;
          if (cnt_q != CNT_FULL) cnt_d = cnt_q + (AW+1)'(1);
        end
        2'b11: begin
          if (cnt_q != '0) begin
            state_d = hist_q[wp_q - AW'(1)];
            wp_d    = wp_q - AW'(1);
            cnt_d   = cnt_q - (AW+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Step counter is independent of history occupancy; a load forces it to zero.
  always_comb begin
    step_d = step_q;
    if (load) begin
      step_d = '0;
    end else if (sif.step_inc && !sif.step_dec) begin
      if (step_q != 8'hff) step_d = step_q + 8'd1;
    end else if (sif.step_dec && !sif.step_inc) begin
      if (step_q != 8'h00) step_d = step_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  always_ff @(posedge clk) begin
    hist_q <= hist_d;
  end

  assign sif.game_state   = state_q;
  assign sif.step         = step_q;
  assign sif.real_retract = (cnt_q != '0);
endmodule

// File: tb/tb_sokoban_state_store.sv
// Directed bench for sokoban_state_store: load/move/retract sequences,
// history overflow, step saturation and reset interactions.
module tb_sokoban_state_store;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sokoban_state_store_if sif();
  sokoban_state_store #(.DEPTH(8), .AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [133:0] st(input int k);
    logic [63:0] w;
    logic [63:0] b;
    w = 64'h1111_0000_0000_0000 | 64'(k * 7 + 1);
    b = 64'h2222_0000_0000_0000 | 64'(k * 3 + 5);
    return {w, b, 6'(k + 1)};
  endfunction

  // Drive one cycle of stimulus; source states are scrambled after the edge.
  task automatic op(input logic en, input logic [1:0] s, input logic inc,
                    input logic dec, input logic [133:0] v);
    sif.game_state_en = en;
    sif.sel           = s;
    sif.step_inc      = inc;
    sif.step_dec      = dec;
    sif.init_state    = v;
    sif.move_state    = v;
    @(posedge clk); #1;
    sif.game_state_en = 1'b0;
    sif.step_inc      = 1'b0;
    sif.step_dec      = 1'b0;
    sif.init_state    = ~v;
    sif.move_state    = ~v;
  endtask

  initial begin
    reset = 1'b1;
    sif.game_state_en = 1'b0;
    sif.sel = 2'b00;
    sif.step_inc = 1'b1;
    sif.step_dec = 1'b0;
    sif.init_state = st(40);
    sif.move_state = st(41);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    sif.step_inc = 1'b0;
    op(1'b0, 2'b00, 1'b0, 1'b0, st(42));
    chk("rst_state", sif.game_state, '0);
    chk("rst_step", sif.step, 0);
    chk("rst_rr", sif.real_retract, 0);

    // load then three moves, three retracts
    op(1'b1, 2'b00, 1'b0, 1'b0, st(0));
    chk("load_s0", sif.game_state, st(0));
    chk("load_rr", sif.real_retract, 0);
    for (int k = 1; k <= 3; k++) op(1'b1, 2'b01, 1'b1, 1'b0, st(k));
    chk("mv_state", sif.game_state, st(3));
    chk("mv_step", sif.step, 3);
    chk("mv_rr", sif.real_retract, 1);
    op(1'b1, 2'b11, 1'b0, 1'b1, '0);
    chk("rt1", sif.game_state, st(2));
    op(1'b1, 2'b11, 1'b0, 1'b1, '0);
    chk("rt2", sif.game_state, st(1));
    op(1'b1, 2'b11, 1'b0, 1'b1, '0);
    chk("rt3", sif.game_state, st(0));
    chk("rt_step", sif.step, 0);
    chk("rt_rr", sif.real_retract, 0);

    // back-to-back move/retract/move/retract
    op(1'b1, 2'b01, 1'b0, 1'b0, st(1));
    op(1'b1, 2'b11, 1'b0, 1'b0, '0);
    chk("b2b_restore", sif.game_state, st(0));
    op(1'b1, 2'b01, 1'b0, 1'b0, st(2));
    chk("b2b_move", sif.game_state, st(2));
    op(1'b1, 2'b11, 1'b0, 1'b0, '0);
    chk("b2b_pop", sif.game_state, st(0));

    // reserved select and idle with retract select
    op(1'b1, 2'b01, 1'b0, 1'b0, st(6));
    op(1'b1, 2'b10, 1'b0, 1'b0, st(7));
    chk("reserved", sif.game_state, st(6));
    op(1'b0, 2'b11, 1'b0, 1'b0, st(7));
    chk("idle_sel11", sif.game_state, st(6));
    chk("idle_rr", sif.real_retract, 1);

    // reset between a move and a retract
    op(1'b1, 2'b01, 1'b1, 1'b0, st(4));
    reset = 1'b1;
    op(1'b1, 2'b11, 1'b1, 1'b0, '0);
    reset = 1'b0;
    chk("midrst_state", sif.game_state, '0);
    chk("midrst_step", sif.step, 0);
    op(1'b1, 2'b11, 1'b0, 1'b0, '0);
    chk("midrst_pop", sif.game_state, '0);
    chk("midrst_rr", sif.real_retract, 0);

    // double load
    op(1'b1, 2'b00, 1'b1, 1'b0, st(0));
    op(1'b1, 2'b00, 1'b1, 1'b0, st(0));
    chk("dload_state", sif.game_state, st(0));
    chk("dload_step", sif.step, 0);

    // history overflow
    for (int k = 1; k <= 10; k++) op(1'b1, 2'b01, 1'b0, 1'b0, st(k));
    chk("ovf_cnt", dut.cnt_q, 8);
    chk("ovf_rr", sif.real_retract, 1);
    op(1'b1, 2'b11, 1'b0, 1'b0, '0);
    chk("ovf_rt1", sif.game_state, st(9));
    for (int k = 0; k < 7; k++) op(1'b1, 2'b11, 1'b0, 1'b0, '0);
    chk("ovf_rt8", sif.game_state, st(2));
    chk("ovf_rr_end", sif.real_retract, 0);
    op(1'b1, 2'b11, 1'b0, 1'b0, '0);
    chk("ovf_rt9", sif.game_state, st(2));

    // empty retract right after load
    op(1'b1, 2'b00, 1'b0, 1'b0, st(0));
    op(1'b1, 2'b11, 1'b0, 1'b1, '0);
    chk("empty_state", sif.game_state, st(0));
    chk("empty_step", sif.step, 0);
    chk("empty_rr", sif.real_retract, 0);

    // step saturation and conflict
    for (int k = 0; k < 260; k++) op(1'b0, 2'b00, 1'b1, 1'b0, '0);
    chk("sat_hi", sif.step, 255);
    op(1'b0, 2'b00, 1'b1, 1'b1, '0);
    chk("both", sif.step, 255);
    op(1'b0, 2'b00, 1'b0, 1'b1, '0);
    chk("dec", sif.step, 254);

    // load clears history
    op(1'b1, 2'b00, 1'b0, 1'b0, st(0));
    op(1'b1, 2'b01, 1'b1, 1'b0, st(1));
    op(1'b1, 2'b01, 1'b1, 1'b0, st(2));
    chk("pre_clr_step", sif.step, 2);
    op(1'b1, 2'b00, 1'b1, 1'b0, st(5));
    chk("clr_state", sif.game_state, st(5));
    chk("clr_step", sif.step, 0);
    chk("clr_rr", sif.real_retract, 0);
    op(1'b1, 2'b11, 1'b0, 1'b0, '0);
    chk("clr_pop", sif.game_state, st(5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
